// File: rtl/cu_decimation_mc.sv
// Multi-channel boxcar decimator: averages 2^rate signed samples per channel and
// emits one averaged frame with a single-cycle data_rdy pulse, optional rounding.

module cu_decimation_mc_lane #(
  parameter int DW       = 16,
  parameter int LOG2_MAX = 5,
  parameter int RW       = 3
) (
  input  logic [DW+LOG2_MAX-1:0] acc,
  input  logic [RW-1:0]          r,
  input  logic                   rnd,
  output logic [DW-1:0]          res,
  output logic                   sat
);
  localparam int SW = DW + LOG2_MAX + 1;
  localparam logic signed [SW-1:0] MAXV = {{(LOG2_MAX+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(LOG2_MAX+2){1'b1}}, {(DW-1){1'b0}}};

  logic signed [SW-1:0] bias, sum, v;

  always_comb begin
    bias = '0;
    if (rnd && r != '0) bias = SW'(1) << (r - RW'(1));
    // one guard bit so the rounding bias can never wrap the accumulator
    sum  = $signed({acc[DW+LOG2_MAX-1], acc}) + bias;
    v    = sum >>> r;
    res  = v[DW-1:0];
    sat  = 1'b0;
    if (v > MAXV) begin
      res = MAXV[DW-1:0];
      sat = 1'b1;
    end else if (v < MINV) begin
      res = MINV[DW-1:0];
      sat = 1'b1;
    end
  end
endmodule

module cu_decimation_mc #(
  parameter int DW       = 16,
  parameter int NCH      = 4,
  parameter int LOG2_MAX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              drdy,
  input  logic [NCH*DW-1:0] datain,
  input  logic [2:0]        rate,
  input  logic              round_en,
  output logic [NCH*DW-1:0] dataout,
  output logic              data_rdy,
  output logic [NCH-1:0]    sat
);
  localparam int AW = DW + LOG2_MAX;
  localparam int RW = $clog2(LOG2_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACC, DUMP} state_t;

  state_t                     state_q, state_d;
  logic [NCH-1:0][AW-1:0]     acc_q, acc_d, ext;
  logic [LOG2_MAX-1:0]        count_q, count_d;
  logic [RW-1:0]              r_lat_q, r_lat_d, rate_c, r_eff;
  logic                       rnd_lat_q, rnd_lat_d;
  logic [NCH-1:0][DW-1:0]     dout_q, dout_d, res;
  logic [NCH-1:0]             sat_q, sat_d, lsat;
  logic                       rdy_q, rdy_d;
  logic                       first, last;
  logic [LOG2_MAX:0]          last_cnt;

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    assign ext[k] = {{LOG2_MAX{datain[k*DW+DW-1]}}, datain[k*DW +: DW]};
    cu_decimation_mc_lane #(.DW(DW), .LOG2_MAX(LOG2_MAX), .RW(RW)) u_lane (
      .acc (acc_q[k]),
      .r   (r_lat_q),
      .rnd (rnd_lat_q),
      .res (res[k]),
      .sat (lsat[k])
    );
  end

  // a sample arriving in DUMP opens the next frame, so the rate is taken fresh there too
  always_comb begin
    rate_c   = (rate > 3'(LOG2_MAX)) ? RW'(LOG2_MAX) : RW'(rate);
    first    = (state_q == DUMP) || (count_q == '0);
    r_eff    = first ? rate_c : r_lat_q;
    last_cnt = ((LOG2_MAX+1)'(1) << r_eff) - (LOG2_MAX+1)'(1);
    last     = ({1'b0, count_q} == last_cnt);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    r_lat_d   = r_lat_q;
    rnd_lat_d = rnd_lat_q;
    dout_d    = dout_q;
    sat_d     = sat_q;
    rdy_d     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACC;
          acc_d   = '0;
          count_d = '0;
        end
        default: begin
          if (state_q == DUMP) begin
            dout_d  = res;
            sat_d   = lsat;
            rdy_d   = 1'b1;
            state_d = ACC;
          end
          if (drdy) begin
            for (int k = 0; k < NCH; k++)
              acc_d[k] = first ? ext[k] : acc_q[k] + ext[k];
            if (first) begin
              r_lat_d   = rate_c;
              rnd_lat_d = round_en;
            end
            if (last) begin
              state_d = DUMP;
              count_d = '0;
            end else begin
              count_d = count_q + LOG2_MAX'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      r_lat_q   <= '0;
      rnd_lat_q <= 1'b0;
      dout_q    <= '0;
      sat_q     <= '0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      r_lat_q   <= r_lat_d;
      rnd_lat_q <= rnd_lat_d;
      dout_q    <= dout_d;
      sat_q     <= sat_d;
      rdy_q     <= rdy_d;
    end
  end

  assign dataout  = dout_q;
  assign sat      = sat_q;
  assign data_rdy = rdy_q;
endmodule

// File: tb/tb_cu_decimation_mc.sv
// Randomised bench for cu_decimation_mc against a frame-level averaging model.
module tb_cu_decimation_mc;
  localparam int DW = 16, NCH = 4, LOG2_MAX = 5;

  logic              clk = 1'b0;
  logic              reset, en, drdy, round_en;
  logic [NCH*DW-1:0] datain;
  logic [2:0]        rate;
  logic [NCH*DW-1:0] dataout;
  logic              data_rdy;
  logic [NCH-1:0]    sat;

  int total = 0, bad = 0;

  cu_decimation_mc #(.DW(DW), .NCH(NCH), .LOG2_MAX(LOG2_MAX)) dut (
    .clk(clk), .reset(reset), .en(en), .drdy(drdy), .datain(datain), .rate(rate),
    .round_en(round_en), .dataout(dataout), .data_rdy(data_rdy), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: collect a frame of 2^r samples, average it, publish two edges later.
  longint            m_sum [NCH];
  int                m_n = 0, m_r = 0;
  bit                m_rnd = 0, m_run = 0, m_pend = 0, m_rdy = 0;
  logic [NCH*DW-1:0] m_pdout = '0, m_dout = '0;
  logic [NCH-1:0]    m_psat = '0, m_sat = '0;

  always @(posedge clk) begin
    m_rdy = 0;
    if (!reset) begin
      m_run = 0; m_n = 0; m_pend = 0; m_dout = '0; m_sat = '0;
    end else if (!en) begin
      m_run = 0; m_n = 0; m_pend = 0;
    end else if (!m_run) begin
      m_run = 1; m_n = 0;
    end else begin
      if (m_pend) begin
        m_rdy = 1; m_dout = m_pdout; m_sat = m_psat; m_pend = 0;
      end
      if (drdy) begin
        if (m_n == 0) begin
          m_r   = (rate > LOG2_MAX) ? LOG2_MAX : int'(rate);
          m_rnd = round_en;
          for (int k = 0; k < NCH; k++) m_sum[k] = 0;
        end
        for (int k = 0; k < NCH; k++) m_sum[k] += longint'($signed(datain[k*DW +: DW]));
        m_n++;
        if (m_n == (1 << m_r)) begin
          for (int k = 0; k < NCH; k++) begin
            longint v;
            v = m_sum[k];
            if (m_rnd && m_r > 0) v += longint'(1) << (m_r - 1);
            v = v >>> m_r;
            m_psat[k] = 1'b0;
            if (v > (longint'(1) << (DW-1)) - 1) begin v = (longint'(1) << (DW-1)) - 1; m_psat[k] = 1'b1; end
            if (v < -(longint'(1) << (DW-1)))    begin v = -(longint'(1) << (DW-1));    m_psat[k] = 1'b1; end
            m_pdout[k*DW +: DW] = v[DW-1:0];
          end
          m_pend = 1; m_n = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("data_rdy", {63'b0, data_rdy}, {63'b0, m_rdy});
    check("dataout", dataout, m_dout);
    check("sat", {60'b0, sat}, {60'b0, m_sat});
  end

  function automatic logic [NCH*DW-1:0] frm(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic drive(input logic d, input logic [NCH*DW-1:0] x);
    @(negedge clk); #1;
    drdy = d; datain = x;
  endtask

  task automatic wait_rdy(input int lim, output bit got);
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge clk);
      if (data_rdy) got = 1;
      #1 drdy = 1'b0;
    end
    if (!got) check("rdy_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit got;
    logic [15:0] c0, c1;
    reset = 0; en = 0; drdy = 0; datain = '0; rate = 0; round_en = 0;
    repeat (2) @(negedge clk);
    check("reset_dataout", dataout, 64'd0);
    check("reset_rdy", {63'b0, data_rdy}, 64'd0);
    #1 reset = 1; en = 1;
    repeat (2) drive(0, '0);

    // 1/2: truncation vs rounding on a 4-sample frame
    for (int rr = 0; rr < 2; rr++) begin
      rate = 2; round_en = rr[0];
      drive(1, frm(10, -3, 5, 7));
      drive(1, frm(11, -3, 5, 7));
      drive(1, frm(12, -3, 5, 7));
      drive(1, frm(13, -2, 5, 7));
      wait_rdy(6, got);
      c0 = dataout[15:0]; c1 = dataout[31:16];
      check(rr ? "t2_ch0_round" : "t1_ch0_trunc", {48'b0, c0}, rr ? 64'd12 : 64'd11);
      check(rr ? "t2_ch1_round" : "t1_ch1_trunc", {48'b0, c1}, 64'hfffd);
    end

    // 3: full-scale inputs with rounding stay in range
    rate = 1; round_en = 1;
    drive(1, frm(32767, 0, -32768, 0));
    drive(1, frm(32767, 0, -32768, 0));
    wait_rdy(6, got);
    check("t3_ch0_max", {48'b0, dataout[15:0]}, 64'h7fff);
    check("t3_ch2_min", {48'b0, dataout[47:32]}, 64'h8000);
    check("t3_sat", {60'b0, sat}, 64'd0);
    drive(1, frm(32767, 0, -32768, 0));
    drive(1, frm(32766, 0, -32768, 0));
    wait_rdy(6, got);
    check("t3b_ch0", {48'b0, dataout[15:0]}, 64'h7fff);

    // 5: rate change mid-frame only affects the following frame
    round_en = 0; rate = 2;
    drive(1, frm(4, 0, 0, 0));
    drive(1, frm(4, 0, 0, 0));
    rate = 3;
    drive(1, frm(4, 0, 0, 0));
    drive(1, frm(8, 0, 0, 0));
    wait_rdy(6, got);
    check("t5_frame4", {48'b0, dataout[15:0]}, 64'd5);
    for (int i = 1; i <= 8; i++) drive(1, frm(i, 0, 0, 0));
    wait_rdy(6, got);
    check("t5_frame8", {48'b0, dataout[15:0]}, 64'd4);

    // 6: aborted frames (en drop, async reset) produce nothing; rate 7 clamps to 32
    rate = 3;
    for (int i = 0; i < 3; i++) drive(1, frm(999, 1, 1, 1));
    drive(0, '0); en = 0;
    drive(0, '0); en = 1;
    drive(0, '0);
    for (int i = 0; i < 3; i++) drive(1, frm(-999, 1, 1, 1));
    drive(0, '0); reset = 0;
    repeat (2) drive(0, '0);
    reset = 1;
    drive(0, '0);
    rate = 7;
    for (int i = 0; i < 32; i++) drive(1, frm(i, -i, 0, 100));
    wait_rdy(6, got);
    check("t6_rate7_ch0", {48'b0, dataout[15:0]}, 64'd15);
    check("t6_rate7_ch1", {48'b0, dataout[31:16]}, 64'hfff0);

    // 4: pass-through, one drdy every other cycle
    rate = 0;
    for (int i = 0; i < 60; i++) begin
      round_en = 1'($urandom);
      drive(1, {$urandom, $urandom});
      drive(0, {$urandom, $urandom});
    end

    // random rates, gaps, rounding and occasional enable drops
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      rate     = 3'($urandom_range(1, 7));
      round_en = 1'($urandom);
      en       = ($urandom % 80) != 0;
      drdy     = 1'($urandom);
      datain   = {$urandom, $urandom};
    end
    en = 1;
    repeat (6) drive(0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
